hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Parametrised hazard unit for the pipelined CPU. It sits beside the IF/ID and ID/EX pipeline registers and tracks destination registers of in-flight instructions in a shift-register scoreboard, one entry per post-ID stage. From that scoreboard it generates:
- IF/ID stall and ID/EX bubble;
- flush on a taken branch;
- per-operand forwarding selects;
- a saturating stall-cycle counter.

`FWD_EN` selects between a stall-only mode and a forwarding mode.

## Interface
Parameters:
- `REG_AW`, 5: register address width.
- `DEPTH`, 3: scoreboard entries, i.e. post-ID stages holding a pending write (EX, MEM, WR). Legal range is 2..7.
- `FWD_EN`, 0: 0 = stall until writeback completes; 1 = forward, stall only on load-use.
- `CNT_W`, 16: stall counter width.

Ports (clock and reset first):
- `clk`  in  1  — the single clock. State updates on the falling edge, the same edge as the pipeline registers.
- `reset`  in  1  — synchronous, active-high.
- `id_valid`  in  1  — ID holds a real instruction.
- `id_rs`, `id_rt`  in  `REG_AW`  — source register addresses.
- `id_uses_rs`, `id_uses_rt`  in  1  — the instruction actually reads that source.
- `id_reg_wr`  in  1  — the ID instruction writes a register.
- `id_rw`  in  `REG_AW`  — resolved destination (after the RegDst mux).
- `id_is_load`  in  1  — the ID instruction is `lw`.
- `br_taken`  in  1  — the branch in EX resolved taken.
- `if_stall`  out  1  — hold the PC and IF/ID register.
- `id_stall`  out  1  — hold the ID stage.
- `ex_bubble`  out  1  — load a NOP into ID/EX.
- `flush`  out  1  — clear IF/ID to a NOP.
- `fwd_sel_a`, `fwd_sel_b`  out  3  — 0 = register file; k = forward from scoreboard stage k.
- `stall_count`  out  `CNT_W`  — saturating count of stall cycles.

## Operation
Scoreboard contents:
- Entries `s[1..DEPTH]`, each holding {valid, rw, is_load}.
- `s[1]` is EX and `s[DEPTH]` is WR.

Source matching:
- A source matches stage k when `s[k].valid`, the source is used, the source address is nonzero, and `s[k].rw` equals the source.
- Register 0 never matches.

Hazard rules:
- `FWD_EN=0`: hazard if either source matches any k in 1..DEPTH. The register file does not bypass, so WR-stage matches also stall.
- `FWD_EN=1`: hazard only if a source matches `s[1]` and `s[1].is_load` is set.

Output equations:
- `fwd_sel_x`: only when `FWD_EN=1` and there is no hazard, it equals the smallest matching k (youngest producer wins); otherwise it is 0.
- `fwd_sel_x` is always 0 when `FWD_EN=0`.
- `if_stall` = `id_stall` = hazard & `id_valid` & !`br_taken`.
- `flush` = `br_taken`.
- `ex_bubble` = `br_taken` | `if_stall` | !`id_valid`.

Scoreboard update on each falling edge:
- Shift: `s[k+1] <= s[k]`; `s[DEPTH]` retires.
- If `ex_bubble`: `s[1] <=` invalid.
- Otherwise: `s[1] <=` {`id_reg_wr` & (`id_rw`≠0), `id_rw`, `id_is_load`}.

Stall counter:
- `stall_count` increments when `if_stall` is high.
- It saturates at 2^`CNT_W`−1 and never wraps.

## Timing
Reset values:
- All entries invalid and `stall_count` = 0.
- All combinational outputs are therefore 0 after reset, except `ex_bubble`, which equals !`id_valid`.

Latency and cycle counts:
- All control outputs are combinational from the registered scoreboard plus the ID/EX inputs. There are zero cycles from an ID change to the stall decision.
- Stall-mode RAW distance of d instructions (d=1 is back-to-back) with `DEPTH`=3: the dependent instruction stalls `DEPTH`−d+1 cycles. For d=1 that is 3 cycles.
- Forward mode, load-use at d=1: exactly 1 stall cycle. In the following cycle the load sits in `s[2]`, so the select is 2.

Boundary conditions:
- `br_taken` together with a hazard: flush wins. `if_stall`=0, `ex_bubble`=1, and the counter does not increment.
- `reset` together with any input: reset wins and the scoreboard clears on that edge.
- Reset during a stall: stall is released the next cycle, because the scoreboard is empty.
- Both sources matching different stages: each select resolves independently.
- `rs`=`rt`: both selects get the same value.

## Structure
- Shared package `cpu_pkg` holds:
  - the scoreboard entry typedef {valid, rw, is_load};
  - forwarding select constants `FWD_RF=0`, `FWD_EX=1`, `FWD_MEM=2`, `FWD_WR=3`.
- One sub-module, `hazard_match`, instantiated twice (rs and rt):
  - inputs: one source address, its use flag, and the scoreboard vector;
  - outputs: a match-any flag, a load-match-at-`s[1]` flag, and a priority-encoded youngest stage index.

## Test plan
- Reset: assert `reset` with random inputs and `id_valid`=1 → `if_stall`=0, `flush`=0, `fwd_sel_a`=`fwd_sel_b`=0, `stall_count`=0; with `id_valid`=0, `ex_bubble`=1.
- `FWD_EN=0`, `DEPTH=3`: `add $3` followed by `add $5,$3,$1` → `if_stall` high exactly 3 cycles, the dependent instruction enters EX on the 4th cycle, `stall_count`=3.
- `FWD_EN=1`: `lw $4` then `add $6,$4,$2` → 1 stall cycle with `ex_bubble`=1; next cycle `fwd_sel_a`=2; `stall_count`=1.
- `FWD_EN=1`: `add $5` then `sub $7,$5,$5` → no stall, `fwd_sel_a`=`fwd_sel_b`=1. Same pattern with one independent instruction between them → select 2.
- Destination `$0` (`id_rw`=0, `id_reg_wr`=1) followed by a reader of `$0` → no stall in either mode, selects 0.
- Load-use hazard with `br_taken`=1 in the same cycle → `flush`=1, `if_stall`=0, `ex_bubble`=1, `stall_count` unchanged, and `s[1]` is invalid after the edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU pipeline types: scoreboard entry layout and forwarding select codes.
package cpu_pkg;

  // Widest register address the scoreboard can hold; narrower addresses are zero-extended.
  localparam int unsigned RW_W  = 8;
  localparam int unsigned SEL_W = 3;

  localparam logic [SEL_W-1:0] FWD_RF  = 3'd0;
  localparam logic [SEL_W-1:0] FWD_EX  = 3'd1;
  localparam logic [SEL_W-1:0] FWD_MEM = 3'd2;
  localparam logic [SEL_W-1:0] FWD_WR  = 3'd3;

  typedef struct packed {
    logic            valid;
    logic [RW_W-1:0] rw;
    logic            is_load;
  } sb_entry_t;

endpackage

// File: rtl/hazard_scoreboard_match.sv
// Compares one source operand against every scoreboard entry.
module hazard_match
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 3
) (
  input  logic                  [RW_W-1:0]  src_i,
  input  logic                              use_i,
  input  sb_entry_t             [DEPTH:1]   sb_i,
  output logic                              any_o,
  output logic                              load_s1_o,
  output logic                  [SEL_W-1:0] stage_o
);

  logic [DEPTH:1] hit;

  // Per-stage match; register 0 is never a real dependency
  always_comb begin
    hit = '0;
    for (int unsigned k = 1; k <= DEPTH; k++) begin
      hit[k] = sb_i[k].valid && use_i && (src_i != '0) && (sb_i[k].rw == src_i);
    end
  end

  assign any_o     = |hit;
  assign load_s1_o = hit[1] && sb_i[1].is_load;

  // Youngest (smallest index) matching producer wins
  always_comb begin
    stage_o = FWD_RF;
    for (int unsigned k = 1; k <= DEPTH; k++) begin
      if (hit[k] && (stage_o == FWD_RF)) begin
        stage_o = SEL_W'(k);
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard unit: shift-register scoreboard of in-flight destinations,
// stall/bubble/flush generation, forwarding selects and a stall-cycle counter.
module hazard_scoreboard
  import cpu_pkg::*;
#(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned DEPTH  = 3,
  parameter int unsigned FWD_EN = 0,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              id_reg_wr,
  input  logic [REG_AW-1:0] id_rw,
  input  logic              id_is_load,
  input  logic              br_taken,
  output logic              if_stall,
  output logic              id_stall,
  output logic              ex_bubble,
  output logic              flush,
  output logic [SEL_W-1:0]  fwd_sel_a,
  output logic [SEL_W-1:0]  fwd_sel_b,
  output logic [CNT_W-1:0]  stall_count
);

  sb_entry_t [DEPTH:1] sb_q, sb_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic             any_a, any_b, ld_a, ld_b, hazard;
  logic [SEL_W-1:0] stage_a, stage_b;

  hazard_match #(.DEPTH(DEPTH)) u_match_rs (
    .src_i     (RW_W'(id_rs)),
    .use_i     (id_uses_rs),
    .sb_i      (sb_q),
    .any_o     (any_a),
    .load_s1_o (ld_a),
    .stage_o   (stage_a)
  );

  hazard_match #(.DEPTH(DEPTH)) u_match_rt (
    .src_i     (RW_W'(id_rt)),
    .use_i     (id_uses_rt),
    .sb_i      (sb_q),
    .any_o     (any_b),
    .load_s1_o (ld_b),
    .stage_o   (stage_b)
  );

  // Stall/flush/forward decisions, combinational from scoreboard and ID inputs
  always_comb begin
    fwd_sel_a = FWD_RF;
    fwd_sel_b = FWD_RF;
    if (FWD_EN != 0) begin
      hazard = ld_a || ld_b;
      if (!hazard) begin
        fwd_sel_a = stage_a;
        fwd_sel_b = stage_b;
      end
    end else begin
      hazard = any_a || any_b;
    end
    if_stall  = hazard && id_valid && !br_taken;
    id_stall  = if_stall;
    flush     = br_taken;
    ex_bubble = br_taken || if_stall || !id_valid;
  end

  // Next scoreboard: shift toward WR, insert the ID instruction or a bubble at EX
  always_comb begin
    sb_d = sb_q;
    for (int unsigned k = 2; k <= DEPTH; k++) begin
      sb_d[k] = sb_q[k-1];
    end
    if (ex_bubble) begin
      sb_d[1] = '0;
    end else begin
      sb_d[1].valid   = id_reg_wr && (id_rw != '0);
      sb_d[1].rw      = RW_W'(id_rw);
      sb_d[1].is_load = id_is_load;
    end
    cnt_d = cnt_q;
    if (if_stall && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State updates on the falling edge alongside the pipeline registers
  always_ff @(negedge clk) begin
    if (reset) begin
      sb_q  <= '0;
      cnt_q <= '0;
    end else begin
      sb_q  <= sb_d;
      cnt_q <= cnt_d;
    end
  end

  assign stall_count = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench: stall-only instance (2-bit counter to reach saturation) and
// forwarding instance share the same ID-stage stimulus.
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid, id_uses_rs, id_uses_rt, id_reg_wr, id_is_load, br_taken;
  logic [4:0] id_rs, id_rt, id_rw;

  logic        s_if_stall, s_id_stall, s_ex_bubble, s_flush;
  logic [2:0]  s_sel_a, s_sel_b;
  logic [1:0]  s_count;
  logic        f_if_stall, f_id_stall, f_ex_bubble, f_flush;
  logic [2:0]  f_sel_a, f_sel_b;
  logic [15:0] f_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(.REG_AW(5), .DEPTH(3), .FWD_EN(0), .CNT_W(2)) u_stall (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_reg_wr(id_reg_wr),
    .id_rw(id_rw), .id_is_load(id_is_load), .br_taken(br_taken),
    .if_stall(s_if_stall), .id_stall(s_id_stall), .ex_bubble(s_ex_bubble),
    .flush(s_flush), .fwd_sel_a(s_sel_a), .fwd_sel_b(s_sel_b), .stall_count(s_count)
  );

  hazard_scoreboard #(.REG_AW(5), .DEPTH(3), .FWD_EN(1), .CNT_W(16)) u_fwd (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_reg_wr(id_reg_wr),
    .id_rw(id_rw), .id_is_load(id_is_load), .br_taken(br_taken),
    .if_stall(f_if_stall), .id_stall(f_id_stall), .ex_bubble(f_ex_bubble),
    .flush(f_flush), .fwd_sel_a(f_sel_a), .fwd_sel_b(f_sel_b), .stall_count(f_count)
  );

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance past the active (falling) edge and let outputs settle
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Present one ID-stage instruction
  task automatic issue(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic wr,
                       input logic [4:0] rw, input logic ld);
    id_valid = v; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
    id_reg_wr = wr; id_rw = rw; id_is_load = ld;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    br_taken = 1'b0;
    issue(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    tick();
    reset = 1'b0;
  endtask

  int n_stall;

  initial begin
    reset = 1'b1;
    br_taken = 1'b0;
    issue(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    tick();
    tick();
    reset = 1'b0;

    // Reset clears a populated scoreboard even with a writer and reader on the inputs
    issue(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0);
    tick();
    reset = 1'b1;
    issue(1'b1, 5'd3, 5'($urandom_range(1, 31)), 1'b1, 1'b1, 1'b1, 5'd3, 1'b1);
    tick();
    check("rst_if_stall_s", s_if_stall, 0);
    check("rst_if_stall_f", f_if_stall, 0);
    check("rst_flush", f_flush, 0);
    check("rst_sel_a", f_sel_a, 0);
    check("rst_sel_b", f_sel_b, 0);
    check("rst_count_s", s_count, 0);
    check("rst_count_f", f_count, 0);
    check("rst_bubble_valid", s_ex_bubble, 0);
    issue(1'b0, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0);
    check("rst_bubble_invalid", s_ex_bubble, 1);
    reset = 1'b0;

    // Stall mode, back-to-back RAW: add $3 ; add $5,$3,$1
    issue(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0);
    check("a_first_no_stall", s_if_stall, 0);
    tick();
    issue(1'b1, 5'd3, 5'd1, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0);
    check("a_id_stall", s_id_stall, 1);
    check("a_bubble", s_ex_bubble, 1);
    n_stall = 0;
    for (int c = 0; c < 8 && s_if_stall; c++) begin
      n_stall++;
      tick();
    end
    check("a_stall_cycles", n_stall, 3);
    check("a_count", s_count, 3);
    check("a_released_bubble", s_ex_bubble, 0);
    tick();
    // Dependent add $5 is now in EX: a reader of $5 must stall
    issue(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0);
    check("a_dep_in_ex", s_if_stall, 1);
    tick();
    tick();
    check("a_count_saturate", s_count, 3);

    // Forward mode load-use: lw $4 ; add $6,$4,$2
    do_reset();
    issue(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd4, 1'b1);
    tick();
    issue(1'b1, 5'd4, 5'd2, 1'b1, 1'b1, 1'b1, 5'd6, 1'b0);
    check("b_stall", f_if_stall, 1);
    check("b_bubble", f_ex_bubble, 1);
    check("b_sel_a_during", f_sel_a, 0);
    tick();
    check("b_released", f_if_stall, 0);
    check("b_sel_a_mem", f_sel_a, 2);
    check("b_sel_b_rf", f_sel_b, 0);
    check("b_count", f_count, 1);

    // Forward mode ALU RAW: add $5 ; sub $7,$5,$5
    do_reset();
    issue(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0);
    tick();
    issue(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0);
    check("c_no_stall", f_if_stall, 0);
    check("c_sel_a", f_sel_a, 1);
    check("c_sel_b", f_sel_b, 1);
    check("c_stall_mode_stalls", s_if_stall, 1);
    check("c_stall_mode_sel", s_sel_a, 0);

    // Distance 2, then operands from different stages
    do_reset();
    issue(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0);
    tick();
    issue(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd8, 1'b0);
    tick();
    issue(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0);
    check("c2_sel_a", f_sel_a, 2);
    check("c2_sel_b", f_sel_b, 2);
    issue(1'b1, 5'd8, 5'd5, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0);
    check("c2_mix_sel_a", f_sel_a, 1);
    check("c2_mix_sel_b", f_sel_b, 2);
    issue(1'b1, 5'd8, 5'd5, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0);
    check("c2_unused_rs", f_sel_a, 0);

    // Writes to $0 never create a dependency
    do_reset();
    issue(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd0, 1'b1);
    tick();
    issue(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0);
    check("d_stall_s", s_if_stall, 0);
    check("d_stall_f", f_if_stall, 0);
    check("d_sel_a", f_sel_a, 0);
    check("d_sel_b", f_sel_b, 0);

    // Load-use together with a taken branch: flush wins
    do_reset();
    issue(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd4, 1'b1);
    tick();
    br_taken = 1'b1;
    issue(1'b1, 5'd4, 5'd2, 1'b1, 1'b1, 1'b1, 5'd6, 1'b0);
    check("e_flush", f_flush, 1);
    check("e_no_stall", f_if_stall, 0);
    check("e_bubble", f_ex_bubble, 1);
    tick();
    br_taken = 1'b0;
    check("e_count", f_count, 0);
    issue(1'b1, 5'd6, 5'd4, 1'b1, 1'b1, 1'b1, 5'd9, 1'b0);
    check("e_s1_empty", f_sel_a, 0);
    check("e_load_in_mem", f_sel_b, 2);
    check("e_after_no_stall", f_if_stall, 0);
    issue(1'b0, 5'd6, 5'd4, 1'b1, 1'b1, 1'b1, 5'd9, 1'b0);
    check("e_invalid_no_stall_s", s_if_stall, 0);

    // Reset during a stall releases it on the next cycle
    do_reset();
    issue(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0);
    tick();
    issue(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0);
    check("f_stalling", s_if_stall, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("f_released", s_if_stall, 0);
    check("f_count_cleared", s_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
